input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter Channels, default 4: number of independent raw button/switch inputs conditioned.
REQ-002 Parameter DebounceCycles, default 500000: consecutive stable clock cycles required before a level change is accepted (10 ms at 50 MHz); legal range 1..2^24.
REQ-003 Parameter ActiveLowMask, default 4'b0011: bit set = raw input is active-low and SHALL be inverted before synchronisation.
REQ-004 Parameter ToggleMask, default 4'b0010: bit set = channel drives o_toggle bit as toggle-on-press latch.
REQ-005 i_clock_50mhz  input  1  single system clock; all state on its rising edge.
REQ-006 i_reset  input  1  asynchronous, active-low reset.
REQ-007 i_raw  input  Channels  raw asynchronous pad inputs (buttons/switches).
REQ-008 o_level  output  Channels  debounced, polarity-corrected level, 1 = active.
REQ-009 o_rise  output  Channels  one-cycle pulse when o_level goes 0->1.
REQ-010 o_fall  output  Channels  one-cycle pulse when o_level goes 1->0.
REQ-011 o_toggle  output  Channels  toggle latch; bits not in ToggleMask SHALL be held 0.

Function
REQ-012 Each channel SHALL pass polarity-corrected i_raw through a two-flop synchroniser; synchronised value appears 2 edges after the raw change.
REQ-013 Each channel SHALL run FSM STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW; o_level = 1 in STABLE_HIGH and PEND_LOW, else 0.
REQ-014 STABLE_LOW -> PEND_HIGH when synchronised value = 1, counter loaded to 1; STABLE_HIGH -> PEND_LOW symmetrically on 0.
REQ-015 In PEND_x, counter SHALL increment each edge the synchronised value still differs from o_level; on reaching DebounceCycles, FSM SHALL enter the opposite STABLE state and clear counter.
REQ-016 In PEND_x, if synchronised value returns to o_level before the count completes, FSM SHALL return to the originating STABLE state and clear counter (glitch rejected, no pulse).
REQ-017 With DebounceCycles = 1, transition SHALL occur on the first differing edge (STABLE -> opposite STABLE directly, PEND unused).
REQ-018 Total latency raw edge -> o_level change SHALL be exactly 2 + DebounceCycles clock edges for a clean input.
REQ-019 o_rise/o_fall SHALL be asserted combinationally-free (registered) in the same cycle o_level first shows its new value, for exactly one cycle.
REQ-020 o_toggle bit SHALL invert on every cycle its o_rise bit is 1 (ToggleMask channels only); o_fall SHALL not affect it.
REQ-021 Counter width SHALL be $clog2(DebounceCycles+1); counter SHALL never wrap or exceed DebounceCycles.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-023 While i_reset = 0: synchroniser flops, counters, o_level, o_rise, o_fall, o_toggle = 0; all FSMs = STABLE_LOW.
REQ-024 Reset assertion mid-PEND SHALL abort the pending change with no pulse; a channel held active through reset release SHALL emit o_rise after 2 + DebounceCycles edges.
REQ-025 Reset deassertion SHALL be treated as synchronous to i_clock_50mhz by the integrator (external reset synchroniser); block SHALL not add one.

Structure
REQ-026 Package input_conditioner_pkg SHALL hold the FSM state enum typedef and default parameter constants (debounce cycles, masks).
REQ-027 Sub-module debounce_channel (sync + FSM + counter + pulse/toggle for one bit) SHALL be instantiated Channels times by generate loop.
REQ-028 Block SHALL sit upstream of the counter datapath, replacing direct pad connections of set, pause, count, type.

Verification (bench uses DebounceCycles = 4, ActiveLowMask = 0, ToggleMask = 4'b0010)
REQ-029 i_raw[0] 0->1 held -> o_level[0] = 1 and o_rise[0] = 1 for one cycle exactly 6 edges later; o_fall stays 0.
REQ-030 i_raw[2] 3-cycle high glitch -> o_level[2], o_rise[2] remain 0 throughout.
REQ-031 i_raw[1] pressed/released twice, each phase 10 cycles -> o_toggle[1] goes 0->1->0, two o_rise[1] and two o_fall[1] pulses.
REQ-032 i_raw = 4'b1111 in one cycle -> o_rise = 4'b1111 in the same cycle, 6 edges later.
REQ-033 i_reset = 0 asserted 2 cycles into PEND_HIGH on channel 0, released with input still high -> no pulse during reset; o_rise[0] 6 edges after release.
REQ-034 ActiveLowMask = 4'b0001, i_raw[0] 1->0 -> o_level[0] = 1 after 6 edges.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// ----------------------------------------------------------------------------
// input_conditioner_pkg
//   Shared definitions for the button/switch input conditioner:
//     - deb_state_e : per-channel debounce FSM state
//     - default constants for channel count, debounce length and masks
// ----------------------------------------------------------------------------
package input_conditioner_pkg;

  // Per-channel debounce FSM. The two PEND states remember which stable
  // level the channel came from, so a glitch can fall back to it.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    PEND_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    PEND_LOW    = 2'd3
  } deb_state_e;

  // 10 ms of stability at a 50 MHz system clock.
  localparam int unsigned DEFAULT_CHANNELS        = 4;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

  // Channels 0 and 1 are wired to active-low pads on the board.
  localparam logic [3:0] DEFAULT_ACTIVE_LOW_MASK = 4'b0011;

  // Channel 1 (pause) behaves as a push-on/push-off latch.
  localparam logic [3:0] DEFAULT_TOGGLE_MASK = 4'b0010;

endpackage : input_conditioner_pkg

// File: rtl/input_conditioner_debounce_channel.sv
// ----------------------------------------------------------------------------
// debounce_channel
//   Conditions one raw pad input: polarity correction, two-flop
//   synchroniser, debounce FSM with a stability counter, and registered
//   rise/fall pulses plus an optional toggle-on-press latch.
//
// Parameters
//   DebounceCycles : consecutive stable edges needed to accept a change
//   ActiveLow      : 1 = raw pad is active-low and is inverted first
//   ToggleEn       : 1 = o_toggle inverts on every accepted press
//
// Ports
//   i_clock_50mhz : system clock, rising edge
//   i_reset       : asynchronous active-low reset
//   i_raw         : raw asynchronous pad input
//   o_level       : debounced level, 1 = active
//   o_rise        : one-cycle pulse when o_level goes 0->1
//   o_fall        : one-cycle pulse when o_level goes 1->0
//   o_toggle      : toggle latch (held 0 when ToggleEn = 0)
// ----------------------------------------------------------------------------
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DebounceCycles = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ActiveLow      = 1'b0,
  parameter bit          ToggleEn       = 1'b0
) (
  input  logic i_clock_50mhz,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_toggle
);

  localparam int unsigned CntW = $clog2(DebounceCycles + 1);

  // The count is loaded to 1 on the edge that enters PEND, so the change
  // is accepted on the edge where the count would reach DebounceCycles.
  // Testing against DebounceCycles-1 keeps the counter below the limit.
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DebounceCycles);

  // Saturating increment: the counter can never wrap past DebounceCycles.
  function automatic logic [CntW-1:0] cnt_inc(input logic [CntW-1:0] c);
    if (c >= CntMax) begin
      return CntMax;
    end
    return c + CntOne;
  endfunction

  logic            raw_active;
  logic            sync_p0;
  logic            sync_p1;
  deb_state_e      state;
  logic [CntW-1:0] cnt;
  logic            level;
  logic            rise;
  logic            fall;
  logic            toggle;

  assign raw_active = ActiveLow ? ~i_raw : i_raw;

  always_ff @(posedge i_clock_50mhz or negedge i_reset) begin
    if (!i_reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      state   <= STABLE_LOW;
      cnt     <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      toggle  <= 1'b0;
    end else begin
      // ---- stage p0/p1: two-flop synchroniser ----
      sync_p0 <= raw_active;
      sync_p1 <= sync_p0;

      // ---- stage p2: debounce FSM on the synchronised value ----
      rise <= 1'b0;
      fall <= 1'b0;

      case (state)
        STABLE_LOW: begin
          if (sync_p1) begin
            if (DebounceCycles == 1) begin
              state  <= STABLE_HIGH;
              level  <= 1'b1;
              rise   <= 1'b1;
              toggle <= ToggleEn ? ~toggle : 1'b0;
            end else begin
              state <= PEND_HIGH;
              cnt   <= CntOne;
            end
          end
        end

        PEND_HIGH: begin
          if (!sync_p1) begin
            // Glitch: fall back silently.
            state <= STABLE_LOW;
            cnt   <= '0;
          end else if (cnt == CntLast) begin
            state  <= STABLE_HIGH;
            cnt    <= '0;
            level  <= 1'b1;
            rise   <= 1'b1;
            toggle <= ToggleEn ? ~toggle : 1'b0;
          end else begin
            cnt <= cnt_inc(cnt);
          end
        end

        STABLE_HIGH: begin
          if (!sync_p1) begin
            if (DebounceCycles == 1) begin
              state <= STABLE_LOW;
              level <= 1'b0;
              fall  <= 1'b1;
            end else begin
              state <= PEND_LOW;
              cnt   <= CntOne;
            end
          end
        end

        PEND_LOW: begin
          if (sync_p1) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CntLast) begin
            state <= STABLE_LOW;
            cnt   <= '0;
            level <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt_inc(cnt);
          end
        end

        default: begin
          state <= STABLE_LOW;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

  assign o_level  = level;
  assign o_rise   = rise;
  assign o_fall   = fall;
  assign o_toggle = ToggleEn ? toggle : 1'b0;

endmodule : debounce_channel

// File: rtl/input_conditioner.sv
// ----------------------------------------------------------------------------
// input_conditioner
//   Front end for the counter datapath's pad inputs (set, pause, count,
//   type). Each raw button/switch is polarity-corrected, synchronised and
//   debounced independently, producing a clean level, edge pulses and an
//   optional toggle latch per channel.
//
// Parameters
//   Channels       : number of independent raw inputs
//   DebounceCycles : stable edges required before a level change (1..2^24)
//   ActiveLowMask  : bit set = raw input is active-low
//   ToggleMask     : bit set = channel drives its o_toggle bit
//
// Ports
//   i_clock_50mhz : system clock, all state on its rising edge
//   i_reset       : asynchronous active-low reset; release must already be
//                   synchronous to i_clock_50mhz
//   i_raw         : raw asynchronous pad inputs
//   o_level       : debounced, polarity-corrected levels (1 = active)
//   o_rise        : one-cycle pulses on o_level 0->1
//   o_fall        : one-cycle pulses on o_level 1->0
//   o_toggle      : toggle latches, 0 for channels outside ToggleMask
// ----------------------------------------------------------------------------
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned          Channels       = DEFAULT_CHANNELS,
  parameter int unsigned          DebounceCycles = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [Channels-1:0]  ActiveLowMask  = DEFAULT_ACTIVE_LOW_MASK,
  parameter logic [Channels-1:0]  ToggleMask     = DEFAULT_TOGGLE_MASK
) (
  input  logic                i_clock_50mhz,
  input  logic                i_reset,
  input  logic [Channels-1:0] i_raw,
  output logic [Channels-1:0] o_level,
  output logic [Channels-1:0] o_rise,
  output logic [Channels-1:0] o_fall,
  output logic [Channels-1:0] o_toggle
);

  for (genvar g = 0; g < Channels; g++) begin : g_chan
    debounce_channel #(
      .DebounceCycles (DebounceCycles),
      .ActiveLow      (ActiveLowMask[g]),
      .ToggleEn       (ToggleMask[g])
    ) u_chan (
      .i_clock_50mhz (i_clock_50mhz),
      .i_reset       (i_reset),
      .i_raw         (i_raw[g]),
      .o_level       (o_level[g]),
      .o_rise        (o_rise[g]),
      .o_fall        (o_fall[g]),
      .o_toggle      (o_toggle[g])
    );
  end

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// ----------------------------------------------------------------------------
// tb_input_conditioner
//   Two instances share clock, reset and raw inputs: dut_a with no
//   active-low channels, dut_b with channel 0 active-low. A window model
//   predicts every output each cycle; directed scenarios add literal checks.
// ----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int          CH   = 4;
  localparam int          D    = 4;
  localparam int          SPAN = D + 2;
  localparam logic [3:0]  TMASK = 4'b0010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] raw = 4'b0000;

  logic [3:0] lvl_a, rise_a, fall_a, tog_a;
  logic [3:0] lvl_b, rise_b, fall_b, tog_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  input_conditioner #(
    .Channels(CH), .DebounceCycles(D), .ActiveLowMask(4'b0000), .ToggleMask(TMASK)
  ) dut_a (
    .i_clock_50mhz(clk), .i_reset(rst_n), .i_raw(raw),
    .o_level(lvl_a), .o_rise(rise_a), .o_fall(fall_a), .o_toggle(tog_a)
  );

  input_conditioner #(
    .Channels(CH), .DebounceCycles(D), .ActiveLowMask(4'b0001), .ToggleMask(TMASK)
  ) dut_b (
    .i_clock_50mhz(clk), .i_reset(rst_n), .i_raw(raw),
    .o_level(lvl_b), .o_rise(rise_b), .o_fall(fall_b), .o_toggle(tog_b)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_hist[u][k] is the polarity-corrected raw value sampled k edges
  // ago (0 = this edge). The FSM sees a sample two edges late, so a level
  // flips exactly when samples 2..D+1 all disagree with the current level.
  logic [3:0] m_hist [2][SPAN];
  logic [3:0] m_lvl  [2];
  logic [3:0] m_rise [2];
  logic [3:0] m_fall [2];
  logic [3:0] m_tog  [2];

  function automatic logic [3:0] pol(input int u);
    return (u == 0) ? 4'b0000 : 4'b0001;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        for (int k = 0; k < SPAN; k++) m_hist[u][k] = 4'b0000;
        m_lvl[u] = 4'b0000; m_rise[u] = 4'b0000;
        m_fall[u] = 4'b0000; m_tog[u] = 4'b0000;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        for (int k = SPAN - 1; k > 0; k--) m_hist[u][k] = m_hist[u][k-1];
        m_hist[u][0] = raw ^ pol(u);
        m_rise[u] = 4'b0000;
        m_fall[u] = 4'b0000;
        for (int c = 0; c < CH; c++) begin
          logic all_diff;
          all_diff = 1'b1;
          for (int j = 0; j < D; j++)
            if (m_hist[u][2+j][c] == m_lvl[u][c]) all_diff = 1'b0;
          if (all_diff) begin
            m_lvl[u][c] = ~m_lvl[u][c];
            if (m_lvl[u][c]) begin
              m_rise[u][c] = 1'b1;
              if (TMASK[c]) m_tog[u][c] = ~m_tog[u][c];
            end else begin
              m_fall[u][c] = 1'b1;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_lvl_a",  lvl_a,  m_lvl[0]);
    chk("model_rise_a", rise_a, m_rise[0]);
    chk("model_fall_a", fall_a, m_fall[0]);
    chk("model_tog_a",  tog_a,  m_tog[0]);
    chk("model_lvl_b",  lvl_b,  m_lvl[1]);
    chk("model_rise_b", rise_b, m_rise[1]);
    chk("model_fall_b", fall_b, m_fall[1]);
    chk("model_tog_b",  tog_b,  m_tog[1]);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic       seen;
    int         n_rise, n_fall;

    // Reset state: everything 0, even dut_b whose channel 0 reads active.
    rst_n = 1'b0; raw = 4'b0000;
    step(3);
    chk("rst_lvl_a", lvl_a, 4'b0000);
    chk("rst_lvl_b", lvl_b, 4'b0000);
    chk("rst_pulses", rise_a | fall_a | rise_b | fall_b, 4'b0000);
    chk("rst_tog", tog_a | tog_b, 4'b0000);
    rst_n = 1'b1;
    step(10);
    chk("b_ch0_idle_active", 4'(lvl_b[0]), 4'd1);

    // Clean press on channel 0: accepted exactly 6 edges later.
    raw = 4'b0001;
    step(5);
    chk("r029_lvl_early",  4'(lvl_a[0]),  4'd0);
    chk("r029_rise_early", 4'(rise_a[0]), 4'd0);
    step(1);
    chk("r029_lvl",  4'(lvl_a[0]),  4'd1);
    chk("r029_rise", 4'(rise_a[0]), 4'd1);
    chk("r029_fall", 4'(fall_a[0]), 4'd0);
    step(1);
    chk("r029_rise_once", 4'(rise_a[0]), 4'd0);
    chk("r029_lvl_hold",  4'(lvl_a[0]),  4'd1);
    raw = 4'b0000;
    step(10);

    // 3-cycle glitch on channel 2 must be rejected.
    raw = 4'b0100;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      seen = seen | lvl_a[2] | rise_a[2];
    end
    raw = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      step(1);
      seen = seen | lvl_a[2] | rise_a[2];
    end
    chk("r030_glitch", 4'(seen), 4'd0);

    // Two press/release cycles on channel 1 (toggle channel).
    n_rise = 0; n_fall = 0;
    for (int p = 0; p < 2; p++) begin
      raw = 4'b0010;
      for (int i = 0; i < 10; i++) begin
        step(1);
        n_rise += int'(rise_a[1]); n_fall += int'(fall_a[1]);
      end
      chk("r031_tog", 4'(tog_a[1]), (p == 0) ? 4'd1 : 4'd0);
      raw = 4'b0000;
      for (int i = 0; i < 10; i++) begin
        step(1);
        n_rise += int'(rise_a[1]); n_fall += int'(fall_a[1]);
      end
    end
    chk("r031_rises", 4'(n_rise), 4'd2);
    chk("r031_falls", 4'(n_fall), 4'd2);
    chk("r031_tog_mask", tog_a & 4'b1101, 4'b0000);

    // All four channels at once.
    raw = 4'b1111;
    step(5);
    chk("r032_rise_early", rise_a, 4'b0000);
    step(1);
    chk("r032_rise_all", rise_a, 4'b1111);
    chk("r032_b_ch0_fall", 4'(fall_b[0]), 4'd1);
    raw = 4'b0000;
    step(12);

    // Reset in the middle of PEND_HIGH on channel 0, input held high.
    raw = 4'b0001;
    step(4);
    rst_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      seen = seen | (|rise_a) | (|lvl_a);
    end
    chk("r033_quiet_in_reset", 4'(seen), 4'd0);
    rst_n = 1'b1;
    step(5);
    chk("r033_rise_early", 4'(rise_a[0]), 4'd0);
    step(1);
    chk("r033_rise", 4'(rise_a[0]), 4'd1);
    step(4);

    // Active-low channel 0 on dut_b: raw 1->0 reads as a press.
    chk("r034_idle", 4'(lvl_b[0]), 4'd0);
    raw = 4'b0000;
    step(5);
    chk("r034_lvl_early", 4'(lvl_b[0]), 4'd0);
    step(1);
    chk("r034_lvl", 4'(lvl_b[0]), 4'd1);
    chk("r034_rise", 4'(rise_b[0]), 4'd1);
    step(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_input_conditioner
